// File: rtl/dmem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dmem_ctrl                                                  |
// | Description : Data-memory access controller between the MA pipeline      |
// |               stage and a request/grant/rvalid bus. Formats store data   |
// |               and byte enables, formats load data, rejects misaligned    |
// |               accesses and stalls the pipeline while a bus access runs.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module dmem_ctrl (
  input  logic        clk,
  input  logic        rst_i,
  // pipeline side
  input  logic        req_valid_i,
  input  logic        rd_en_i,
  input  logic        wr_en_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        misaligned_o,
  // bus side
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_WAIT_R = 2'd2;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;

  logic [1:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [29:0] addr_q, addr_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;

  logic        accept;
  logic        misaligned;
  logic        launch;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;

  // Qualify the incoming request; reset masks every pipeline input
  always_comb begin
    accept = !rst_i && (state_q == S_IDLE) && req_valid_i && (rd_en_i || wr_en_i);
    case (size_i)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = addr_i[0];
      SZ_WORD: misaligned = |addr_i[1:0];
      default: misaligned = 1'b1;
    endcase
    launch = accept && !misaligned;
  end

  // Store formatting: lane-replicated data and enables (also used as load enables)
  always_comb begin
    case (size_i)
      SZ_BYTE: begin
        fmt_wdata = {4{wdata_i[7:0]}};
        fmt_be    = 4'b0001 << addr_i[1:0];
      end
      SZ_HALF: begin
        fmt_wdata = {2{wdata_i[15:0]}};
        fmt_be    = addr_i[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        fmt_wdata = wdata_i;
        fmt_be    = 4'b1111;
      end
    endcase
  end

  // Load formatting: pick the addressed lane, then sign- or zero-extend
  always_comb begin
    lane_byte = bus_rdata_i[{off_q, 3'b000} +: 8];
    lane_half = off_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    case (size_q)
      SZ_BYTE: load_data = {{24{sign_q & lane_byte[7]}}, lane_byte};
      SZ_HALF: load_data = {{16{sign_q & lane_half[15]}}, lane_half};
      default: load_data = bus_rdata_i;
    endcase
  end

  // Capture the transaction attributes when an aligned request launches
  always_comb begin
    we_d    = we_q;
    addr_d  = addr_q;
    off_d   = off_q;
    size_d  = size_q;
    sign_d  = sign_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    if (launch) begin
      we_d    = wr_en_i;
      addr_d  = addr_i[31:2];
      off_d   = addr_i[1:0];
      size_d  = size_i;
      sign_d  = sign_i;
      be_d    = fmt_be;
      wdata_d = fmt_wdata;
    end
  end

  // Transaction attribute registers
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      off_q   <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic; rvalid only matters in WAIT_R
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (launch) state_d = S_REQ;
      S_REQ:    if (bus_gnt_i) state_d = we_q ? S_IDLE : S_WAIT_R;
      S_WAIT_R: if (bus_rvalid_i) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs; state_q is IDLE during reset and accept is masked, so all read 0
  always_comb begin
    stall_o       = 1'b0;
    misaligned_o  = 1'b0;
    rdata_valid_o = 1'b0;
    rdata_o       = '0;
    bus_req_o     = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_o      = launch;
        misaligned_o = accept && misaligned;
      end
      S_REQ: begin
        bus_req_o = 1'b1;
        stall_o   = !(bus_gnt_i && we_q);
      end
      S_WAIT_R: begin
        stall_o       = !bus_rvalid_i;
        rdata_valid_o = bus_rvalid_i;
        rdata_o       = bus_rvalid_i ? load_data : 32'd0;
      end
      default: ;
    endcase
  end

  assign bus_we_o    = we_q;
  assign bus_addr_o  = {addr_q, 2'b00};
  assign bus_be_o    = be_q;
  assign bus_wdata_o = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_dmem_ctrl                                               |
// | Description : Self-checking bench for dmem_ctrl: directed vector table,  |
// |               reset sequences and randomized transactions against a     |
// |               transaction-level reference model.                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i, rd_en_i, wr_en_i, sign_i;
  logic [31:0] addr_i, wdata_i;
  logic [1:0]  size_i;
  logic        stall_o, rdata_valid_o, misaligned_o;
  logic [31:0] rdata_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i, bus_rvalid_i;
  logic [31:0] bus_rdata_i;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sign;
    int          gdly;      // REQ cycles without grant before the grant cycle
    int          rdly;      // WAIT_R cycles without rvalid before the data cycle
    logic        early;     // rvalid pulse in the grant cycle (must be ignored)
    logic [31:0] rdata;     // bus read data returned for a load
    logic        exp_mis;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  dmem_ctrl dut (
    .clk           (clk),
    .rst_i         (rst_i),
    .req_valid_i   (req_valid_i),
    .rd_en_i       (rd_en_i),
    .wr_en_i       (wr_en_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .size_i        (size_i),
    .sign_i        (sign_i),
    .stall_o       (stall_o),
    .rdata_o       (rdata_o),
    .rdata_valid_o (rdata_valid_o),
    .misaligned_o  (misaligned_o),
    .bus_req_o     (bus_req_o),
    .bus_we_o      (bus_we_o),
    .bus_addr_o    (bus_addr_o),
    .bus_be_o      (bus_be_o),
    .bus_wdata_o   (bus_wdata_o),
    .bus_gnt_i     (bus_gnt_i),
    .bus_rvalid_i  (bus_rvalid_i),
    .bus_rdata_i   (bus_rdata_i)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (arithmetic on the access rules) -------
  function automatic int m_bytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic int m_lo(input logic [31:0] a, input logic [1:0] sz);
    int n;
    n = m_bytes(sz);
    return ((a % 4) / n) * n;   // lowest byte lane touched by the access
  endfunction

  function automatic logic m_mis(input logic [31:0] a, input logic [1:0] sz);
    return (sz == 2'd3) || ((a % m_bytes(sz)) != 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] a, input logic [1:0] sz);
    int v;
    v = ((1 << m_bytes(sz)) - 1) << m_lo(a, sz);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] d, input logic [1:0] sz);
    if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [31:0] raw, input logic [31:0] a,
                                          input logic [1:0] sz, input logic sg);
    logic [63:0] v;
    int          bits;
    bits = 8 * m_bytes(sz);
    v    = 64'(raw) >> (8 * m_lo(a, sz));
    if (bits < 32) begin
      v = v % (64'd1 << bits);
      if (sg && (v >= (64'd1 << (bits - 1)))) v = v - (64'd1 << bits);
    end
    return v[31:0];
  endfunction

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] size, input logic sign,
                              input int gdly, input int rdly, input logic early,
                              input logic [31:0] rdata, input logic mis, input logic [3:0] be,
                              input logic [31:0] ewd, input logic [31:0] erd);
    vec_t t;
    t.rd = rd; t.wr = wr; t.addr = addr; t.wdata = wdata; t.size = size; t.sign = sign;
    t.gdly = gdly; t.rdly = rdly; t.early = early; t.rdata = rdata;
    t.exp_mis = mis; t.exp_be = be; t.exp_wdata = ewd; t.exp_rdata = erd;
    return t;
  endfunction

  // ---------------- stimulus helpers (called at posedge + 1) ---------------
  task automatic idle_inputs();
    req_valid_i = 1'b0; rd_en_i = 1'b0; wr_en_i = 1'b0;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
  endtask

  task automatic idle_cycle();
    idle_inputs();
    bus_rvalid_i = 1'($urandom % 2);
    bus_rdata_i  = $urandom;
    @(negedge clk);
    chk1("idle.stall", stall_o, 1'b0);
    chk1("idle.bus_req", bus_req_o, 1'b0);
    chk1("idle.rdata_valid", rdata_valid_o, 1'b0);
    chk32("idle.rdata", rdata_o, 32'd0);
    chk1("idle.misaligned", misaligned_o, 1'b0);
    @(posedge clk); #1;
  endtask

  // Accept cycle; returns whether a bus transaction was launched
  task automatic accept_cycle(input vec_t t, output logic launched);
    logic acc;
    acc = t.rd | t.wr;
    req_valid_i = 1'b1; rd_en_i = t.rd; wr_en_i = t.wr;
    addr_i = t.addr; wdata_i = t.wdata; size_i = t.size; sign_i = t.sign;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'($urandom % 2); bus_rdata_i = $urandom;
    @(negedge clk);
    chk1("accept.misaligned", misaligned_o, acc & t.exp_mis);
    chk1("accept.stall", stall_o, acc & !t.exp_mis);
    chk1("accept.bus_req", bus_req_o, 1'b0);
    chk1("accept.rdata_valid", rdata_valid_o, 1'b0);
    @(posedge clk); #1;
    // scramble the pipeline inputs to prove the attributes were latched
    req_valid_i = 1'b0; rd_en_i = 1'b0; wr_en_i = 1'b0;
    addr_i = $urandom; wdata_i = $urandom; size_i = 2'($urandom); sign_i = 1'($urandom);
    launched = acc & !t.exp_mis;
  endtask

  task automatic req_check(input vec_t t, input logic exp_stall);
    @(negedge clk);
    chk1("req.bus_req", bus_req_o, 1'b1);
    chk1("req.bus_we", bus_we_o, t.wr);
    chk32("req.bus_addr", bus_addr_o, {t.addr[31:2], 2'b00});
    chk32("req.bus_be", {28'd0, bus_be_o}, {28'd0, t.exp_be});
    if (t.wr) chk32("req.bus_wdata", bus_wdata_o, t.exp_wdata);
    chk1("req.stall", stall_o, exp_stall);
    chk1("req.rdata_valid", rdata_valid_o, 1'b0);
    chk32("req.rdata", rdata_o, 32'd0);
  endtask

  task automatic run_txn(input vec_t t);
    logic launched;
    accept_cycle(t, launched);
    if (launched) begin
      for (int i = 0; i <= t.gdly; i++) begin
        bus_gnt_i    = (i == t.gdly);
        bus_rvalid_i = (i == t.gdly) ? t.early : 1'($urandom % 2);
        bus_rdata_i  = $urandom;
        req_check(t, (i < t.gdly) ? 1'b1 : !t.wr);
        @(posedge clk); #1;
      end
      bus_gnt_i = 1'b0;
      if (!t.wr) begin
        for (int j = 0; j <= t.rdly; j++) begin
          bus_rvalid_i = (j == t.rdly);
          bus_rdata_i  = (j == t.rdly) ? t.rdata : $urandom;
          @(negedge clk);
          chk1("wait.bus_req", bus_req_o, 1'b0);
          chk1("wait.rdata_valid", rdata_valid_o, j == t.rdly);
          chk1("wait.stall", stall_o, j != t.rdly);
          chk32("wait.rdata", rdata_o, (j == t.rdly) ? t.exp_rdata : 32'd0);
          @(posedge clk); #1;
        end
      end
      bus_rvalid_i = 1'b0;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, ".bus_req"}, bus_req_o, 1'b0);
    chk1({tag, ".bus_we"}, bus_we_o, 1'b0);
    chk32({tag, ".bus_addr"}, bus_addr_o, 32'd0);
    chk32({tag, ".bus_be"}, {28'd0, bus_be_o}, 32'd0);
    chk32({tag, ".bus_wdata"}, bus_wdata_o, 32'd0);
    chk1({tag, ".stall"}, stall_o, 1'b0);
    chk1({tag, ".rdata_valid"}, rdata_valid_o, 1'b0);
    chk32({tag, ".rdata"}, rdata_o, 32'd0);
    chk1({tag, ".misaligned"}, misaligned_o, 1'b0);
  endtask

  // ---------------- test sequence ------------------------------------------
  vec_t tbl[13];

  initial begin
    vec_t t;
    logic launched;

    // rd, wr, addr, wdata, size, sign, gdly, rdly, early, rdata, mis, be, wdata, rdata
    tbl[0]  = mk(0, 1, 32'h1003, 32'h0000_00A5, 2'd0, 0, 0, 0, 0, 32'h0, 0, 4'b1000, 32'hA5A5_A5A5, 32'h0);
    tbl[1]  = mk(1, 0, 32'h2002, 32'h0, 2'd1, 1, 3, 2, 0, 32'h8001_FFFF, 0, 4'b1100, 32'h0, 32'hFFFF_8001);
    tbl[2]  = mk(1, 0, 32'h2002, 32'h0, 2'd1, 0, 3, 2, 0, 32'h8001_FFFF, 0, 4'b1100, 32'h0, 32'h0000_8001);
    tbl[3]  = mk(1, 0, 32'h3002, 32'h0, 2'd2, 0, 0, 0, 0, 32'h0, 1, 4'b0000, 32'h0, 32'h0);
    tbl[4]  = mk(0, 1, 32'h0040, 32'h1234_5678, 2'd2, 0, 0, 0, 0, 32'h0, 0, 4'b1111, 32'h1234_5678, 32'h0);
    tbl[5]  = mk(1, 0, 32'h0044, 32'h0, 2'd2, 0, 0, 0, 0, 32'h1234_5678, 0, 4'b1111, 32'h0, 32'h1234_5678);
    tbl[6]  = mk(1, 0, 32'h0051, 32'h0, 2'd0, 1, 1, 2, 1, 32'h1122_8033, 0, 4'b0010, 32'h0, 32'hFFFF_FF80);
    tbl[7]  = mk(0, 1, 32'h0062, 32'hCAFE_BEEF, 2'd1, 0, 2, 0, 0, 32'h0, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    tbl[8]  = mk(1, 0, 32'h0065, 32'h0, 2'd1, 0, 0, 0, 0, 32'h0, 1, 4'b0000, 32'h0, 32'h0);
    tbl[9]  = mk(0, 1, 32'h0070, 32'h0, 2'd3, 0, 0, 0, 0, 32'h0, 1, 4'b0000, 32'h0, 32'h0);
    tbl[10] = mk(1, 1, 32'h0080, 32'h0000_007E, 2'd0, 0, 1, 0, 0, 32'h0, 0, 4'b0001, 32'h7E7E_7E7E, 32'h0);
    tbl[11] = mk(1, 0, 32'h0092, 32'h0, 2'd0, 0, 0, 1, 0, 32'hABCD_EF01, 0, 4'b0100, 32'h0, 32'h0000_00CD);
    tbl[12] = mk(1, 0, 32'h00A0, 32'h0, 2'd1, 1, 0, 0, 1, 32'h1234_F00D, 0, 4'b0011, 32'h0, 32'hFFFF_F00D);

    // reset with a live-looking request on the inputs: everything must read 0
    rst_i = 1'b1;
    idle_inputs();
    req_valid_i = 1'b1; wr_en_i = 1'b1; addr_i = 32'h10; wdata_i = 32'h55; size_i = 2'd2; sign_i = 1'b0;
    bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
    #3;
    chk_reset_outputs("reset");
    @(posedge clk); @(posedge clk); #1;
    chk_reset_outputs("reset_held");
    rst_i = 1'b0;

    // directed vectors, back to back from the first cycle after reset
    for (int k = 0; k < 13; k++) run_txn(tbl[k]);
    idle_cycle();

    // reset while in WAIT_R, then a late rvalid must be ignored
    t = mk(1, 0, 32'h0100, 32'h0, 2'd2, 0, 0, 0, 0, 32'h0, 0, 4'b1111, 32'h0, 32'h0);
    accept_cycle(t, launched);
    bus_gnt_i = 1'b1; bus_rvalid_i = 1'b0;
    req_check(t, 1'b1);
    @(posedge clk); #1;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
    @(negedge clk);
    chk1("wait_r.stall", stall_o, 1'b1);
    #2 rst_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hDEAD_BEEF;
    #1 chk_reset_outputs("rst_in_wait");
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk1("post_rst.rdata_valid", rdata_valid_o, 1'b0);
    chk1("post_rst.stall", stall_o, 1'b0);
    chk1("post_rst.bus_req", bus_req_o, 1'b0);
    @(posedge clk); #1;
    bus_rvalid_i = 1'b0;
    run_txn(tbl[0]);

    // reset while in REQ abandons the bus request immediately
    t = mk(1, 0, 32'h0204, 32'h0, 2'd2, 0, 0, 0, 0, 32'h0, 0, 4'b1111, 32'h0, 32'h0);
    accept_cycle(t, launched);
    bus_gnt_i = 1'b0;
    req_check(t, 1'b1);
    #2 rst_i = 1'b1;
    #1 chk_reset_outputs("rst_in_req");
    @(posedge clk); #1;
    rst_i = 1'b0;
    run_txn(tbl[5]);

    // randomized transactions checked against the reference model
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a, d, raw;
      logic [1:0]  sz;
      logic        rd, wr, sg;
      int          kind;
      kind = int'($urandom % 8);
      rd   = (kind >= 1 && kind <= 3) || kind == 7;
      wr   = (kind >= 4);
      sz   = 2'($urandom % 4);
      a    = $urandom;
      if ($urandom % 2 == 1) a = a & ~32'(m_bytes(sz) - 1);
      d    = $urandom;
      raw  = $urandom;
      sg   = 1'($urandom % 2);
      t = mk(rd, wr, a, d, sz, sg, int'($urandom % 4), int'($urandom % 4), 1'($urandom % 2), raw,
             m_mis(a, sz), m_mis(a, sz) ? 4'b0000 : m_be(a, sz), m_wdata(d, sz), m_rdata(raw, a, sz, sg));
      run_txn(t);
      if ($urandom % 3 == 0) idle_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
